// File: rtl/bsg_lfu_pkg.sv
// Shared types for the LFU frequency store: op codes, FSM states, freq vector.
package bsg_lfu_pkg;

  typedef enum logic [1:0] {
    OP_HIT   = 2'd0,
    OP_FILL  = 2'd1,
    OP_INVAL = 2'd2,
    OP_READ  = 2'd3
  } bsg_lfu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_AGE  = 1'b1
  } bsg_lfu_stat_state_e;

  localparam int unsigned lfu_ways_def_lp = 8;
  localparam int unsigned lfu_freq_def_lp = 16;

  // Default-geometry freq vector, way w at [w*lfu_freq_def_lp +: lfu_freq_def_lp]
  typedef logic [lfu_ways_def_lp*lfu_freq_def_lp-1:0] bsg_lfu_freq_t;

endpackage

// File: rtl/bsg_lfu_stat_ctr.sv
// One saturating frequency counter; controls resolve clr > load1 > halve > inc.
module bsg_lfu_stat_ctr
  import bsg_lfu_pkg::*;
#(
  parameter int lg_freq_lp = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  inc_i,
  input  logic                  load1_i,
  input  logic                  clr_i,
  input  logic                  halve_i,
  output logic [lg_freq_lp-1:0] value_o,
  output logic                  at_max_o
);

  logic [lg_freq_lp-1:0] r_val;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)             r_val <= '0;
    else if (clr_i)             r_val <= '0;
    else if (load1_i)           r_val <= lg_freq_lp'(1);
    else if (halve_i)           r_val <= r_val >> 1;
    else if (inc_i && !at_max_o) r_val <= r_val + 1'b1;
  end

  assign at_max_o = &r_val;
  assign value_o  = r_val;

endmodule

// File: rtl/bsg_lfu_stat.sv
// Per-set/per-way LFU frequency store with saturation-triggered set aging
// and a registered one-cycle read port.
module bsg_lfu_stat
  import bsg_lfu_pkg::*;
#(
  parameter int ways_p     = 8,
  parameter int lg_ways_lp = 3,
  parameter int lg_freq_lp = 16,
  parameter int sets_p     = 64,
  parameter int lg_sets_lp = 6
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         v_i,
  output logic                         ready_o,
  input  logic [1:0]                   op_i,
  input  logic [lg_sets_lp-1:0]        set_i,
  input  logic [lg_ways_lp-1:0]        way_i,
  output logic                         v_o,
  output logic [ways_p*lg_freq_lp-1:0] freq_o
);

  bsg_lfu_stat_state_e          r_state;
  logic [lg_sets_lp-1:0]        r_age_set;
  logic                         r_v;
  logic [ways_p*lg_freq_lp-1:0] r_freq;

  bsg_lfu_op_e                  w_op;
  logic                         w_acc;
  logic                         w_in_range;
  logic                         w_trig;
  logic [lg_freq_lp-1:0]        w_ctr    [sets_p][ways_p];
  logic                         w_at_max [sets_p][ways_p];
  logic [ways_p*lg_freq_lp-1:0] w_row;
  logic [lg_freq_lp-1:0]        w_cur;
  logic                         w_cur_max;

  assign w_op       = bsg_lfu_op_e'(op_i);
  assign w_acc      = v_i && (r_state == ST_IDLE);
  assign w_in_range = (int'(set_i) < sets_p);

  for (genvar s = 0; s < sets_p; s++) begin : g_set
    for (genvar w = 0; w < ways_p; w++) begin : g_way
      logic w_sel;
      assign w_sel = w_acc && (set_i == lg_sets_lp'(s)) && (way_i == lg_ways_lp'(w));

      bsg_lfu_stat_ctr #(.lg_freq_lp(lg_freq_lp)) u_ctr (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .inc_i     (w_sel && (w_op == OP_HIT)),
        .load1_i   (w_sel && (w_op == OP_FILL)),
        .clr_i     (w_sel && (w_op == OP_INVAL)),
        .halve_i   ((r_state == ST_AGE) && (r_age_set == lg_sets_lp'(s))),
        .value_o   (w_ctr[s][w]),
        .at_max_o  (w_at_max[s][w])
      );
    end
  end

  // Out-of-range sets fall through with an all-zero row and never trigger aging
  always_comb begin
    w_row     = '0;
    w_cur     = '0;
    w_cur_max = 1'b0;
    for (int s = 0; s < sets_p; s++) begin
      if (int'(set_i) == s) begin
        for (int w = 0; w < ways_p; w++) begin
          w_row[w*lg_freq_lp +: lg_freq_lp] = w_ctr[s][w];
          if (int'(way_i) == w) begin
            w_cur     = w_ctr[s][w];
            w_cur_max = w_at_max[s][w];
          end
        end
      end
    end
  end

  // Post-increment equals MAX when the counter is already MAX or MAX-1
  assign w_trig = w_cur_max || (w_cur == {{(lg_freq_lp-1){1'b1}}, 1'b0});

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state   <= ST_IDLE;
      r_age_set <= '0;
      r_v       <= 1'b0;
      r_freq    <= '0;
    end else begin
      r_v <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_acc && (w_op == OP_READ)) begin
            r_v    <= 1'b1;
            r_freq <= w_row;
          end
          if (w_acc && (w_op == OP_HIT) && w_in_range && w_trig) begin
            r_state   <= ST_AGE;
            r_age_set <= set_i;
          end
        end
        ST_AGE:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ready_o = (r_state == ST_IDLE);
  assign v_o     = r_v;
  assign freq_o  = r_freq;

endmodule

// File: tb/tb_bsg_lfu_stat.sv
// Bench for bsg_lfu_stat at 4 ways x 4 sets x 4-bit counters, plus a 3-set
// instance for out-of-range set handling.
module tb_bsg_lfu_stat;

  logic        clk_i;
  logic        reset_n_i;
  logic        v_i;
  logic        ready_o;
  logic [1:0]  op_i;
  logic [1:0]  set_i;
  logic [1:0]  way_i;
  logic        v_o;
  logic [15:0] freq_o;

  logic        b_v;
  logic        b_ready;
  logic [1:0]  b_op;
  logic [1:0]  b_set;
  logic [1:0]  b_way;
  logic        b_vo;
  logic [15:0] b_freq;

  int total;
  int bad;

  // Reference model: plain counter array and pending-age flag
  int          m [4][4];
  bit          m_age;
  int          m_age_set;
  bit          m_v;
  logic [15:0] m_freq;

  bsg_lfu_stat #(.ways_p(4), .lg_ways_lp(2), .lg_freq_lp(4), .sets_p(4), .lg_sets_lp(2)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready_o), .op_i(op_i),
    .set_i(set_i), .way_i(way_i), .v_o(v_o), .freq_o(freq_o)
  );

  bsg_lfu_stat #(.ways_p(4), .lg_ways_lp(2), .lg_freq_lp(4), .sets_p(3), .lg_sets_lp(2)) dut_b (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(b_v), .ready_o(b_ready), .op_i(b_op),
    .set_i(b_set), .way_i(b_way), .v_o(b_vo), .freq_o(b_freq)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [15:0] pack(input int s);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[k*4 +: 4] = 4'(m[s][k]);
    return r;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 4; k++) m[s][k] = 0;
    m_age = 0; m_age_set = 0; m_v = 0; m_freq = '0;
  endtask

  // Drive one op at the negedge, apply the spec rules at the posedge, return at the next negedge
  task automatic cycle(input bit v, input int o, input int s, input int w);
    v_i = v; op_i = 2'(o); set_i = 2'(s); way_i = 2'(w);
    @(posedge clk_i);
    m_v = 0;
    if (m_age) begin
      for (int k = 0; k < 4; k++) m[m_age_set][k] = m[m_age_set][k] / 2;
      m_age = 0;
    end else if (v) begin
      case (o)
        0: begin
          if (m[s][w] < 15) m[s][w] = m[s][w] + 1;
          if (m[s][w] == 15) begin m_age = 1; m_age_set = s; end
        end
        1: m[s][w] = 1;
        2: m[s][w] = 0;
        default: begin m_v = 1; m_freq = pack(s); end
      endcase
    end
    @(negedge clk_i);
    v_i = 0;
  endtask

  task automatic b_cycle(input int o, input int s, input int w);
    b_v = 1; b_op = 2'(o); b_set = 2'(s); b_way = 2'(w);
    @(negedge clk_i);
    b_v = 0;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    #3;
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready_o); end
    total++; if (v_o !== 1'b0) begin bad++; $display("FAIL reset_v_o got=%b want=0", v_o); end
    total++; if (freq_o !== 16'h0) begin bad++; $display("FAIL reset_freq got=%h want=0000", freq_o); end
    #8 reset_n_i = 1'b1;
    @(negedge clk_i);
    model_clear();
    cycle(1, 3, 2, 0);
    total++; if (v_o !== 1'b1) begin bad++; $display("FAIL read2_v_o got=%b want=1", v_o); end
    total++; if (freq_o !== 16'h0) begin bad++; $display("FAIL read2_freq got=%h want=0000", freq_o); end
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL read2_ready got=%b want=1", ready_o); end
    cycle(0, 0, 0, 0);
    total++; if (v_o !== 1'b0) begin bad++; $display("FAIL v_o_pulse got=%b want=0", v_o); end
  endtask

  task automatic test_hit_count();
    cycle(1, 1, 1, 3);
    cycle(1, 3, 1, 0);
    total++; if (freq_o !== m_freq || freq_o !== 16'h1000) begin bad++; $display("FAIL fill_read got=%h want=1000", freq_o); end
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 1, 3);
      cycle(1, 3, 1, 0);
      total++; if (v_o !== 1'b1 || freq_o !== m_freq) begin bad++; $display("FAIL hit_read%0d got=%h want=%h", i, freq_o, m_freq); end
    end
    total++; if (freq_o !== 16'h4000) begin bad++; $display("FAIL hit_final got=%h want=4000", freq_o); end
  endtask

  task automatic test_age();
    cycle(1, 1, 0, 1);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 1);
    cycle(1, 1, 0, 0);
    for (int i = 0; i < 14; i++) cycle(1, 0, 0, 0);
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL age_ready got=%b want=0", ready_o); end
    cycle(1, 1, 2, 0);
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL age_one_cycle got=%b want=1", ready_o); end
    cycle(1, 3, 0, 0);
    total++; if (freq_o !== 16'h0047 || freq_o !== m_freq) begin bad++; $display("FAIL age_read got=%h want=0047", freq_o); end
    cycle(1, 3, 2, 0);
    total++; if (freq_o !== 16'h0000) begin bad++; $display("FAIL age_ignored got=%h want=0000", freq_o); end
    cycle(1, 3, 1, 0);
    total++; if (freq_o !== 16'h4000) begin bad++; $display("FAIL age_other_set got=%h want=4000", freq_o); end
  endtask

  task automatic test_inval();
    cycle(1, 1, 3, 1);
    for (int i = 0; i < 5; i++) cycle(1, 0, 3, 1);
    cycle(1, 3, 3, 0);
    total++; if (freq_o !== 16'h0060) begin bad++; $display("FAIL pre_inval got=%h want=0060", freq_o); end
    cycle(1, 2, 3, 1);
    cycle(1, 3, 3, 0);
    total++; if (freq_o !== 16'h0000 || freq_o !== m_freq) begin bad++; $display("FAIL inval got=%h want=0000", freq_o); end
  endtask

  task automatic test_reset_mid_age();
    cycle(1, 1, 2, 0);
    for (int i = 0; i < 14; i++) cycle(1, 0, 2, 0);
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL mid_age_entry got=%b want=0", ready_o); end
    reset_n_i = 1'b0;
    #1;
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL mid_age_ready got=%b want=1", ready_o); end
    model_clear();
    #1 reset_n_i = 1'b1;
    @(negedge clk_i);
    for (int s = 0; s < 4; s++) begin
      cycle(1, 3, s, 0);
      total++; if (v_o !== 1'b1 || freq_o !== 16'h0) begin bad++; $display("FAIL mid_age_clear set=%0d v=%b got=%h want=0000", s, v_o, freq_o); end
    end
  endtask

  task automatic test_random();
    bit v;
    int o;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3));
      cycle(v, o, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      total++; if (ready_o !== !m_age) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", i, ready_o, !m_age); end
      total++; if (v_o !== m_v) begin bad++; $display("FAIL rnd_v_o cyc=%0d got=%b want=%b", i, v_o, m_v); end
      total++; if (freq_o !== m_freq) begin bad++; $display("FAIL rnd_freq cyc=%0d got=%h want=%h", i, freq_o, m_freq); end
    end
  endtask

  task automatic test_oob();
    b_cycle(1, 0, 0);
    for (int i = 0; i < 15; i++) begin
      b_cycle(0, 3, 0);
      total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL oob_hit_ready i=%0d got=%b want=1", i, b_ready); end
    end
    b_cycle(3, 3, 0);
    total++; if (b_vo !== 1'b1 || b_freq !== 16'h0) begin bad++; $display("FAIL oob_read v=%b got=%h want=0000", b_vo, b_freq); end
    b_cycle(3, 0, 0);
    total++; if (b_freq !== 16'h0001) begin bad++; $display("FAIL oob_set0 got=%h want=0001", b_freq); end
    b_cycle(1, 3, 1);
    b_cycle(3, 3, 0);
    total++; if (b_vo !== 1'b1 || b_freq !== 16'h0) begin bad++; $display("FAIL oob_fill v=%b got=%h want=0000", b_vo, b_freq); end
  endtask

  initial begin
    total = 0; bad = 0;
    reset_n_i = 1'b1;
    v_i = 0; op_i = 0; set_i = 0; way_i = 0;
    b_v = 0; b_op = 0; b_set = 0; b_way = 0;
    model_clear();
    #1;
    test_reset();
    test_hit_count();
    test_age();
    test_inval();
    test_reset_mid_age();
    test_random();
    test_oob();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
